hash_target_checker: RTL and testbench



---
 rtl/mining_pkg.sv | 30 +++
 rtl/hash_target_checker_if.sv | 13 +
 rtl/word_cmp32.sv | 34 +++
 rtl/hash_target_checker.sv | 180 ++++++++++++++++++
 tb/tb_hash_target_checker.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mining_pkg.sv
// Shared mining datapath definitions: digest geometry, checker state codes
// and the byte-order helper used by the checker and by preprocessing.
package mining_pkg;

  localparam int HASH_W    = 256;
  localparam int NONCE_W   = 32;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = HASH_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE_DISARMED = 3'd0,
    ST_ARMED         = 3'd1,
    ST_COMPARE       = 3'd2,
    ST_RESULT        = 3'd3,
    ST_FOUND         = 3'd4,
    ST_EXHAUSTED     = 3'd5
  } state_t;

  // Reverses byte order so a little-endian digest compares as a big number.
  function automatic logic [HASH_W-1:0] byte_reverse(input logic [HASH_W-1:0] d);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < HASH_W / 8; i++) begin
      r[i*8 +: 8] = d[HASH_W-8-i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/hash_target_checker_if.sv
// Digest stream from the compression stage into the target checker.
interface hash_target_checker_if;
  import mining_pkg::*;

  logic [HASH_W-1:0]  hash_in;
  logic [NONCE_W-1:0] nonce_in;
  logic               hash_valid;
  logic               hash_ready;

  modport master (output hash_in, output nonce_in, output hash_valid, input hash_ready);
  modport slave  (input hash_in, input nonce_in, input hash_valid, output hash_ready);

endinterface

// File: rtl/word_cmp32.sv
// Sticky word-serial magnitude comparator: the first unequal word pair
// decides the outcome, later words are ignored until clear.
module word_cmp32
  import mining_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              lt,
  output logic              gt,
  output logic              eq_sofar
);

  logic lt_reg;
  logic gt_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lt_reg <= 1'b0;
      gt_reg <= 1'b0;
    end else if (en && !(lt_reg || gt_reg)) begin
      lt_reg <= (a < b);
      gt_reg <= (a > b);
    end
  end

  assign lt       = lt_reg;
  assign gt       = gt_reg;
  assign eq_sofar = ~(lt_reg | gt_reg);

endmodule

// File: rtl/hash_target_checker.sv
// Checks finished digests against the difficulty target, MS word first over
// 8 cycles, counts attempts and latches the first winning nonce/digest.
module hash_target_checker
  import mining_pkg::*;
#(
  parameter bit BYTE_REVERSE = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [HASH_W-1:0]   target_in,
  input  logic [CNT_W-1:0]    max_attempts,
  hash_target_checker_if.slave hs,
  input  logic                found_ack,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   found_hash,
  output logic [CNT_W-1:0]    attempts,
  output logic                exhausted,
  output logic                busy
);

  state_t              state_reg;
  state_t              state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [HASH_W-1:0]   target_reg;
  logic [HASH_W-1:0]   value_reg;
  logic [HASH_W-1:0]   digest_reg;
  logic [HASH_W-1:0]   found_hash_reg;
  logic [NONCE_W-1:0]  nonce_reg;
  logic [NONCE_W-1:0]  found_nonce_reg;
  logic [CNT_W-1:0]    budget_reg;
  logic [CNT_W-1:0]    attempts_reg;
  logic [CNT_W-1:0]    attempts_next;
  logic                found_reg;
  logic                exhausted_reg;

  logic                transfer;
  logic                cmp_en;
  logic                result_hit;
  logic                result_exhaust;
  logic                cmp_lt;
  logic                cmp_gt;
  logic                cmp_eq;

  logic [WORD_W-1:0]   value_words  [NUM_WORDS];
  logic [WORD_W-1:0]   target_words [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
    assign value_words[gi]  = value_reg[gi*WORD_W +: WORD_W];
    assign target_words[gi] = target_reg[gi*WORD_W +: WORD_W];
  end

  word_cmp32 u_cmp (
    .clock    (clock),
    .reset    (reset),
    .clear    (transfer),
    .en       (cmp_en),
    .a        (value_words[idx_reg]),
    .b        (target_words[idx_reg]),
    .lt       (cmp_lt),
    .gt       (cmp_gt),
    .eq_sofar (cmp_eq)
  );

  // Saturating increment keeps a free-running search from wrapping to zero.
  assign attempts_next = (&attempts_reg) ? attempts_reg : attempts_reg + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE_DISARMED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    transfer       = 1'b0;
    cmp_en         = 1'b0;
    result_hit     = 1'b0;
    result_exhaust = 1'b0;
    case (state_reg)
      ST_ARMED: begin
        if (hs.hash_valid) begin
          transfer   = 1'b1;
          state_next = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        cmp_en = 1'b1;
        if (idx_reg == '0) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        // Equality counts as a hit, so only a strictly greater value misses.
        if (cmp_lt || cmp_eq) begin
          result_hit = 1'b1;
          state_next = ST_FOUND;
        end else if ((budget_reg != '0) && (attempts_next == budget_reg)) begin
          result_exhaust = 1'b1;
          state_next     = ST_EXHAUSTED;
        end else begin
          state_next = ST_ARMED;
        end
      end
      ST_FOUND: begin
        if (found_ack) begin
          state_next = ST_ARMED;
        end
      end
      default: begin
      end
    endcase
    if (start) begin
      state_next     = ST_ARMED;
      transfer       = 1'b0;
      cmp_en         = 1'b0;
      result_hit     = 1'b0;
      result_exhaust = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_reg         <= '0;
      target_reg      <= '0;
      value_reg       <= '0;
      digest_reg      <= '0;
      nonce_reg       <= '0;
      budget_reg      <= '0;
      attempts_reg    <= '0;
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
      found_nonce_reg <= '0;
      found_hash_reg  <= '0;
    end else if (start) begin
      target_reg      <= target_in;
      budget_reg      <= max_attempts;
      attempts_reg    <= '0;
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
      found_nonce_reg <= '0;
      found_hash_reg  <= '0;
    end else begin
      if (transfer) begin
        value_reg  <= BYTE_REVERSE ? byte_reverse(hs.hash_in) : hs.hash_in;
        digest_reg <= hs.hash_in;
        nonce_reg  <= hs.nonce_in;
        idx_reg    <= IDX_W'(NUM_WORDS - 1);
      end else if (cmp_en) begin
        idx_reg <= idx_reg - IDX_W'(1);
      end
      if (state_reg == ST_RESULT) begin
        attempts_reg <= attempts_next;
      end
      // The reported digest is the one received, not the reversed copy.
      if (result_hit) begin
        found_reg       <= 1'b1;
        found_nonce_reg <= nonce_reg;
        found_hash_reg  <= digest_reg;
      end else if (result_exhaust) begin
        exhausted_reg <= 1'b1;
      end else if ((state_reg == ST_FOUND) && found_ack) begin
        found_reg <= 1'b0;
      end
    end
  end

  assign hs.hash_ready = (state_reg == ST_ARMED);
  assign busy          = (state_reg == ST_COMPARE);
  assign found         = found_reg;
  assign found_nonce   = found_nonce_reg;
  assign found_hash    = found_hash_reg;
  assign attempts      = attempts_reg;
  assign exhausted     = exhausted_reg;

endmodule

// File: tb/tb_hash_target_checker.sv
// Drives a straight-order and a byte-reversed checker with the same digests
// and checks both against a transaction-level model every cycle.
module tb_hash_target_checker;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         found_ack;
  logic         hash_valid;
  logic [255:0] target_in;
  logic [255:0] hash_in;
  logic [31:0]  max_attempts;
  logic [31:0]  nonce_in;

  logic         found_o  [2];
  logic [31:0]  fnonce_o [2];
  logic [255:0] fhash_o  [2];
  logic [31:0]  att_o    [2];
  logic         exh_o    [2];
  logic         busy_o   [2];
  logic         rdy_o    [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  hash_target_checker_if if0 ();
  hash_target_checker_if if1 ();

  assign if0.hash_in    = hash_in;
  assign if0.nonce_in   = nonce_in;
  assign if0.hash_valid = hash_valid;
  assign if1.hash_in    = hash_in;
  assign if1.nonce_in   = nonce_in;
  assign if1.hash_valid = hash_valid;
  assign rdy_o[0]       = if0.hash_ready;
  assign rdy_o[1]       = if1.hash_ready;

  hash_target_checker #(.BYTE_REVERSE(1'b0), .CNT_W(32)) dut0 (
    .clock(clock), .reset(reset), .start(start), .target_in(target_in),
    .max_attempts(max_attempts), .hs(if0), .found_ack(found_ack),
    .found(found_o[0]), .found_nonce(fnonce_o[0]), .found_hash(fhash_o[0]),
    .attempts(att_o[0]), .exhausted(exh_o[0]), .busy(busy_o[0])
  );

  hash_target_checker #(.BYTE_REVERSE(1'b1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .start(start), .target_in(target_in),
    .max_attempts(max_attempts), .hs(if1), .found_ack(found_ack),
    .found(found_o[1]), .found_nonce(fnonce_o[1]), .found_hash(fhash_o[1]),
    .attempts(att_o[1]), .exhausted(exh_o[1]), .busy(busy_o[1])
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rev_bytes(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Model: outcome decided by plain arithmetic at acceptance, published 9 edges later.
  logic [255:0] m_target [2];
  logic [255:0] m_fhash  [2];
  logic [255:0] p_hash   [2];
  logic [31:0]  m_budget [2];
  logic [31:0]  m_att    [2];
  logic [31:0]  m_fnonce [2];
  logic [31:0]  p_nonce  [2];
  logic         m_found  [2];
  logic         m_exh    [2];
  logic         m_ready  [2];
  logic         p_hit    [2];
  int           m_cd     [2];

  task automatic model_step();
    logic [255:0] val;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_target[d] = '0; m_budget[d] = '0; m_att[d] = '0; m_fhash[d] = '0;
        m_fnonce[d] = '0; m_found[d] = 1'b0; m_exh[d] = 1'b0; m_ready[d] = 1'b0; m_cd[d] = 0;
      end else if (start) begin
        m_target[d] = target_in; m_budget[d] = max_attempts; m_att[d] = '0; m_fhash[d] = '0;
        m_fnonce[d] = '0; m_found[d] = 1'b0; m_exh[d] = 1'b0; m_ready[d] = 1'b1; m_cd[d] = 0;
      end else if (m_cd[d] > 0) begin
        m_cd[d]--;
        if (m_cd[d] == 0) begin
          if (m_att[d] != 32'hFFFF_FFFF) m_att[d]++;
          if (p_hit[d]) begin
            m_found[d] = 1'b1; m_fnonce[d] = p_nonce[d]; m_fhash[d] = p_hash[d];
          end else if (m_budget[d] != 0 && m_att[d] == m_budget[d]) begin
            m_exh[d] = 1'b1;
          end else begin
            m_ready[d] = 1'b1;
          end
          $display("txn dut%0d nonce=%08h %s attempts=%0d", d, p_nonce[d],
                   p_hit[d] ? "hit" : "miss", m_att[d]);
        end
      end else if (m_ready[d] && hash_valid) begin
        val        = (d == 1) ? rev_bytes(hash_in) : hash_in;
        p_hit[d]   = (val <= m_target[d]);
        p_hash[d]  = hash_in;
        p_nonce[d] = nonce_in;
        m_ready[d] = 1'b0;
        m_cd[d]    = 9;
      end else if (m_found[d] && found_ack) begin
        m_found[d] = 1'b0;
        m_ready[d] = 1'b1;
      end
    end
  endtask

  always @(posedge clock) begin
    model_step();
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d found", d), found_o[d], m_found[d]);
      check($sformatf("d%0d found_nonce", d), fnonce_o[d], m_fnonce[d]);
      check($sformatf("d%0d found_hash", d), fhash_o[d], m_fhash[d]);
      check($sformatf("d%0d attempts", d), att_o[d], m_att[d]);
      check($sformatf("d%0d exhausted", d), exh_o[d], m_exh[d]);
      check($sformatf("d%0d busy", d), busy_o[d], m_cd[d] > 1);
      check($sformatf("d%0d hash_ready", d), rdy_o[d], m_ready[d]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic do_start(input logic [255:0] t, input logic [31:0] m);
    target_in    = t;
    max_attempts = m;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic send(input logic [255:0] h, input logic [31:0] n);
    check("send ready", rdy_o[0], 1'b1);
    hash_in    = h;
    nonce_in   = n;
    hash_valid = 1'b1;
    tick(1);
    hash_valid = 1'b0;
    tick(9);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] t2;
    logic [255:0] h;
    int           last;
    int           w;

    reset = 1'b1; start = 1'b0; found_ack = 1'b0; hash_valid = 1'b0;
    target_in = '0; hash_in = '0; max_attempts = '0; nonce_in = '0;
    tick(3);
    check("rst found", found_o[0], 1'b0);
    check("rst attempts", att_o[0], 32'd0);
    check("rst hash_ready", rdy_o[0], 1'b0);
    check("rst busy", busy_o[0], 1'b0);
    reset = 1'b0;
    tick(1);
    check("idle hash_ready", rdy_o[0], 1'b0);

    // Test 1: basic hit and fixed latency
    do_start({32'h0, {224{1'b1}}}, 32'd0);
    check("t1 armed", rdy_o[0], 1'b1);
    hash_in = 256'h1; nonce_in = 32'hA5A5_0001; hash_valid = 1'b1;
    tick(1);
    hash_valid = 1'b0;
    tick(8);
    check("t1 found early", found_o[0], 1'b0);
    tick(1);
    check("t1 found", found_o[0], 1'b1);
    check("t1 found_nonce", fnonce_o[0], 32'hA5A5_0001);
    check("t1 found_hash", fhash_o[0], 256'h1);
    check("t1 attempts", att_o[0], 32'd1);
    tick(3);
    check("t1 ready held low", rdy_o[0], 1'b0);
    found_ack = 1'b1;
    tick(1);
    found_ack = 1'b0;
    check("t1 ack clears found", found_o[0], 1'b0);
    check("t1 ack rearms", rdy_o[0], 1'b1);
    check("t1 nonce retained", fnonce_o[0], 32'hA5A5_0001);

    // Test 2: equality hits, target+1 misses; target_in changes are ignored while armed
    t2 = 256'h0000_1234_5678_9ABC_DEF0_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_1020_3040_5060;
    do_start(t2, 32'd0);
    send(t2, 32'h2);
    check("t2 eq found", found_o[0], 1'b1);
    found_ack = 1'b1;
    tick(1);
    found_ack = 1'b0;
    target_in = {256{1'b1}};
    send(t2 + 256'd1, 32'h3);
    check("t2 plus1 found", found_o[0], 1'b0);
    check("t2 attempts", att_o[0], 32'd2);
    check("t2 rearmed", rdy_o[0], 1'b1);
    check("t2 nonce retained", fnonce_o[0], 32'h2);

    // Test 3: byte order decides hit vs miss
    do_start({8'h00, {248{1'b1}}}, 32'd0);
    h = {8'hFF, {30{8'h11}}, 8'h00};
    send(h, 32'h33);
    check("t3 straight found", found_o[0], 1'b0);
    check("t3 reversed found", found_o[1], 1'b1);
    check("t3 reversed hash unreversed", fhash_o[1], h);

    // Test 4: budget of three misses with target 0
    do_start(256'h0, 32'd3);
    for (int k = 0; k < 3; k++) send(256'd1 << (k * 100), 32'h40 + k);
    check("t4 exhausted", exh_o[0], 1'b1);
    check("t4 attempts", att_o[0], 32'd3);
    hash_valid = 1'b1;
    tick(5);
    check("t4 ready low", rdy_o[0], 1'b0);
    check("t4 attempts held", att_o[0], 32'd3);
    hash_valid = 1'b0;
    do_start(256'h0, 32'd0);
    check("t4 restart exhausted", exh_o[0], 1'b0);
    check("t4 restart attempts", att_o[0], 32'd0);
    check("t4 restart armed", rdy_o[0], 1'b1);

    // All-ones target: every digest hits
    do_start({256{1'b1}}, 32'd0);
    send({256{1'b1}}, 32'h55);
    check("ones found", found_o[0], 1'b1);

    // Test 5: hash_valid held high across five digests
    do_start({1'b0, {255{1'b1}}}, 32'd0);
    hash_valid = 1'b1;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      h = {8'hF0, 240'h0, 8'hF0};
      hash_in  = h | (256'(k + 1) << 16);
      nonce_in = 32'd100 + 32'(k);
      w = 0;
      while (!rdy_o[0] && w < 20) begin
        tick(1);
        w++;
      end
      if (w >= 20) check("t5 ready timeout", 1'b0, 1'b1);
      if (k > 0) check("t5 spacing", 256'(cyc - last), 256'd10);
      last = cyc;
      tick(1);
    end
    hash_valid = 1'b0;
    tick(9);
    check("t5 attempts", att_o[0], 32'd5);

    // Test 6: reset mid-compare, then start beats found_ack
    do_start(256'h0, 32'd0);
    hash_in = 256'h7; nonce_in = 32'h66; hash_valid = 1'b1;
    tick(1);
    hash_valid = 1'b0;
    tick(3);
    check("t6 busy", busy_o[0], 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6 rst busy", busy_o[0], 1'b0);
    check("t6 rst attempts", att_o[0], 32'd0);
    check("t6 rst ready", rdy_o[0], 1'b0);
    check("t6 rst found", found_o[0], 1'b0);
    tick(1);
    do_start(256'h0, 32'd0);
    send(256'h0, 32'h77);
    check("t6 zero hits", found_o[0], 1'b1);
    target_in = {256{1'b1}};
    start = 1'b1; found_ack = 1'b1;
    tick(1);
    start = 1'b0; found_ack = 1'b0;
    check("t6 start found", found_o[0], 1'b0);
    check("t6 start nonce", fnonce_o[0], 32'd0);
    check("t6 start hash", fhash_o[0], 256'h0);
    check("t6 start attempts", att_o[0], 32'd0);
    check("t6 start armed", rdy_o[0], 1'b1);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
